// File: rtl/conv_pkg.sv
// Shared geometry, widths and FSM state type for the 3x3 streaming convolution engine.
package conv_pkg;

  localparam int IMG_DIM  = 6;
  localparam int K_DIM    = 3;
  localparam int OUT_DIM  = 4;
  localparam int ACC_W    = 20;
  localparam int PIX_W    = 8;
  localparam int PROD_W   = 17;
  localparam int NUM_PIX  = IMG_DIM * IMG_DIM;
  localparam int NUM_TAPS = K_DIM * K_DIM;

  localparam logic [5:0] PIX_LAST = 6'(NUM_PIX - 1);
  localparam logic [3:0] POS_LAST = 4'(OUT_DIM * OUT_DIM - 1);
  localparam logic [1:0] K_LAST   = 2'(K_DIM - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    EMIT,
    DONE
  } conv_state_t;

  function automatic logic [5:0] img_index(input logic [2:0] row, input logic [2:0] col);
    return 6'(int'(row) * IMG_DIM + int'(col));
  endfunction

  function automatic logic [3:0] tap_index(input logic [1:0] kr, input logic [1:0] kc);
    return 4'(int'(kr) * K_DIM + int'(kc));
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate for one output position, plus shift-and-clamp of the running sum.
// result_next reflects the sum including the current tap, so it can be registered on the last tap.
module conv_mac
  import conv_pkg::*;
#(
  parameter int SHIFT = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clear,
  input  logic [PIX_W-1:0]    pixel,
  input  logic [PIX_W-1:0]    weight,
  output logic [PIX_W-1:0]    result_next
);

  logic signed [PROD_W-1:0] pix_ext;
  logic signed [PROD_W-1:0] wt_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  shifted;

  // Pixel is unsigned, weight is two's complement.
  assign pix_ext  = $signed({{(PROD_W-PIX_W){1'b0}}, pixel});
  assign wt_ext   = $signed({{(PROD_W-PIX_W){weight[PIX_W-1]}}, weight});
  assign prod     = pix_ext * wt_ext;
  assign prod_ext = $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
  assign acc_base = clear ? '0 : acc;
  assign acc_next = acc_base + prod_ext;
  assign shifted  = acc_next >>> SHIFT;

  always_comb begin
    result_next = shifted[PIX_W-1:0];
    if (shifted[ACC_W-1]) begin
      result_next = '0;
    end else if (|shifted[ACC_W-2:PIX_W]) begin
      result_next = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/conv_stream_tx.sv
// Buffers a 6x6 frame, then streams sixteen 3x3 convolution results in 2x2 pooling-group order.
// One result every 10 cycles (9 MAC taps + 1 emit cycle); En marks the last result of each group.
module conv_stream_tx
  import conv_pkg::*;
#(
  parameter int SHIFT = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_TAPS-1:0][PIX_W-1:0] kernel,
  input  logic [PIX_W-1:0]               pixel_in,
  input  logic                           pixel_valid,
  output logic [PIX_W-1:0]               convResult,
  output logic                           conv_valid,
  output logic                           En,
  output logic                           busy,
  output logic                           done
);

  conv_state_t state;
  logic [5:0]  pix_cnt;
  logic [3:0]  pos;
  logic [1:0]  kr;
  logic [1:0]  kc;

  logic [PIX_W-1:0]               img [0:NUM_PIX-1];
  logic [NUM_TAPS-1:0][PIX_W-1:0] kern;

  logic [1:0]       out_r;
  logic [1:0]       out_c;
  logic [2:0]       rd_row;
  logic [2:0]       rd_col;
  logic [5:0]       pix_addr;
  logic [3:0]       tap_addr;
  logic [PIX_W-1:0] pix_rd;
  logic [PIX_W-1:0] mac_result;
  logic             mac_en;
  logic             mac_clear;
  logic             last_tap;

  // pos[3:2] selects the pooling group (TL,TR,BL,BR), pos[1:0] the slot within it.
  assign out_r     = {pos[3], pos[1]};
  assign out_c     = {pos[2], pos[0]};
  assign rd_row    = {1'b0, out_r} + {1'b0, kr};
  assign rd_col    = {1'b0, out_c} + {1'b0, kc};
  assign pix_addr  = img_index(rd_row, rd_col);
  assign tap_addr  = tap_index(kr, kc);
  assign pix_rd    = img[pix_addr];
  assign mac_en    = (state == MAC);
  assign mac_clear = (kr == 2'd0) && (kc == 2'd0);
  assign last_tap  = (kr == K_LAST) && (kc == K_LAST);

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      kern <= kernel;
    end
    if (state == LOAD && pixel_valid) begin
      img[pix_cnt] <= pixel_in;
    end
  end

  conv_mac #(
    .SHIFT (SHIFT)
  ) u_mac (
    .clk         (clk),
    .rst         (rst),
    .en          (mac_en),
    .clear       (mac_clear),
    .pixel       (pix_rd),
    .weight      (kern[tap_addr]),
    .result_next (mac_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      pos        <= '0;
      kr         <= '0;
      kc         <= '0;
      convResult <= '0;
      conv_valid <= 1'b0;
      En         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      conv_valid <= 1'b0;
      En         <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            pix_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          if (pixel_valid) begin
            if (pix_cnt == PIX_LAST) begin
              state   <= MAC;
              pix_cnt <= '0;
              pos     <= '0;
              kr      <= '0;
              kc      <= '0;
            end else begin
              pix_cnt <= pix_cnt + 6'd1;
            end
          end
        end
        MAC: begin
          // The result is captured on the last tap so it appears exactly in the EMIT cycle.
          if (last_tap) begin
            kr         <= '0;
            kc         <= '0;
            state      <= EMIT;
            convResult <= mac_result;
            conv_valid <= 1'b1;
            En         <= (pos[1:0] == 2'b11);
          end else if (kc == K_LAST) begin
            kc <= '0;
            kr <= kr + 2'd1;
          end else begin
            kc <= kc + 2'd1;
          end
        end
        EMIT: begin
          if (pos == POS_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            pos   <= pos + 4'd1;
            state <= MAC;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
